// File: rtl/mem_ctrl_pkg.sv
// Shared types and default parameters for the MAR/MDR memory access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } mc_state_e;

  localparam int DEF_DW      = 16;
  localparam int DEF_AW      = 16;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/mem_req_timer.sv
// Wait-state counter for an outstanding memory request; saturates rather than wrapping.
module mem_req_timer
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] SAT  = TW'(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [TW-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the last permitted wait cycle so the FSM leaves on that edge.
  assign expire = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR memory controller: latches an operation, runs a req/ack handshake with
// a wait-state timeout, and reports completion to the CPU FSM via ready.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int            DW       = DEF_DW,
  parameter int            AW       = DEF_AW,
  parameter int            TIMEOUT  = DEF_TIMEOUT,
  parameter logic [DW-1:0] ERR_DATA = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_mar,
  input  logic          ld_mdr,
  input  logic          rw,
  input  logic          mio_en,
  input  logic          clr_err,
  input  logic [DW-1:0] from_bus,
  output logic [DW-1:0] bus_out,
  output logic          ready,
  output logic          busy,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  mc_state_e     state, state_nxt;
  logic [DW-1:0] mar, mdr, rd_hold;
  logic          op_we;
  logic          expire;
  logic          start_op, got_ack, timed_out;

  assign start_op  = (state == S_IDLE) && mio_en;
  assign got_ack   = (state == S_WAIT) && mem_ack;
  assign timed_out = (state == S_WAIT) && !mem_ack && expire;

  mem_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_op),
    .enable (state == S_WAIT),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mio_en) state_nxt = S_WAIT;
      S_WAIT:  if (got_ack || timed_out) state_nxt = S_DONE;
      S_DONE:  if (!mio_en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so bus_out and read data are
  // defined after reset instead of carrying X into the CPU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (ld_mar) mar <= from_bus;
      if (ld_mdr) mdr <= mio_en ? rd_hold : from_bus;
    end
  end

  // Address, data and direction are frozen at operation start so later MAR/MDR
  // loads cannot disturb a request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
    end else if (start_op) begin
      op_we     <= rw;
      mem_addr  <= mar[AW-1:0];
      mem_wdata <= mdr;
      mem_req   <= 1'b1;
    end else if (got_ack || timed_out) begin
      mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hold <= '0;
    end else if (!op_we) begin
      if (got_ack)        rd_hold <= mem_rdata;
      else if (timed_out) rd_hold <= ERR_DATA;
    end
  end

  // A timeout in the same cycle as clr_err leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err <= 1'b0;
    else if (timed_out) err <= 1'b1;
    else if (clr_err)   err <= 1'b0;
  end

  assign bus_out = mdr;
  assign mem_we  = op_we;
  assign busy    = (state == S_WAIT);
  assign ready   = (state == S_DONE);

endmodule
